fft_transpose_buffer: RTL and testbench

FFT_TRANSPOSE_BUFFER -- requirements
Module: fft_transpose_buffer

---
 rtl/fft_transpose_buffer.sv | 123 ++++++++++++
 tb/tb_fft_transpose_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_transpose_buffer.sv
// ---------------------------------------------------------------------------
// fft_transpose_buffer
//
// Ping-pong corner-turn buffer between the two radix-4 butterfly stages of a
// 16-point FFT. Stage 1 writes four 4-lane words (w0..w3) into one bank. The
// other bank is drained one lane index at a time. Output beat k therefore
// carries {w3[k], w2[k], w1[k], w0[k]}. A third bank is not needed, because
// one bank can fill while the other drains.
//
// Parameters
//   CW          width of one real or imaginary component (Q8.8, 2's complement)
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   in_valid    a stage-1 word is present on data_in
//   in_ready    the buffer can take data_in this cycle (registered decode)
//   data_in     four complex lanes; lane i at [2*CW*i +: 2*CW], {Re, Im}
//   out_valid   a transposed word is present on data_out
//   out_ready   the downstream butterfly consumes data_out this cycle
//   data_out    transposed word, same lane layout as data_in
//   rotation    twiddle select {1'b1, beat index}, meaningful with out_valid
//   frame_done  one-cycle pulse after the last beat of a frame is consumed
// ---------------------------------------------------------------------------
module fft_transpose_buffer #(
    parameter int CW = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*CW-1:0] data_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8*CW-1:0] data_out,
    output logic [2:0]      rotation,
    output logic            frame_done
);

    localparam int LW = 2 * CW;

    // Bank storage. It is not reset: contents only matter behind full[].
    logic [8*CW-1:0] bank_mem [2][4];

    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] wr_cnt;
    logic [1:0] rd_cnt;
    logic [1:0] full;
    logic [1:0] full_nxt;

    logic wr_en;
    logic rd_en;
    logic wr_last;
    logic rd_last;

    // Both handshakes decode from registers only. No combinational path
    // runs from out_ready to in_ready.
    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign rotation  = {1'b1, rd_cnt};

    assign wr_en   = in_valid & in_ready;
    assign rd_en   = out_valid & out_ready;
    assign wr_last = wr_en & (wr_cnt == 2'd3);
    assign rd_last = rd_en & (rd_cnt == 2'd3);

    // A write needs !full and a read needs full. The two updates can
    // therefore never target the same bit in one cycle.
    always_comb begin
        full_nxt = full;
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= 2'd0;
            rd_cnt     <= 2'd0;
            full       <= 2'b00;
            frame_done <= 1'b0;
        end else begin
            full       <= full_nxt;
            frame_done <= rd_last;
            if (wr_en) begin
                wr_cnt <= wr_cnt + 2'd1;
                if (wr_cnt == 2'd3) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_en) begin
                rd_cnt <= rd_cnt + 2'd1;
                if (rd_cnt == 2'd3) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_mem[wr_bank][wr_cnt] <= data_in;
        end
    end

    // Corner turn: output lane j is lane rd_cnt of entry w[j] in the read bank.
    always_comb begin
        logic [8*CW-1:0] entry;
        data_out = '0;
        entry    = '0;
        for (int j = 0; j < 4; j++) begin
            entry = bank_mem[rd_bank][j];
            data_out[j*LW +: LW] = entry[int'(rd_cnt)*LW +: LW];
        end
    end

endmodule

// File: tb/tb_fft_transpose_buffer.sv
module tb_fft_transpose_buffer;

    localparam int CW = 17;
    localparam int LW = 2 * CW;
    localparam int DW = 8 * CW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic [2:0]    rotation;
    logic          frame_done;

    fft_transpose_buffer #(.CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .rotation   (rotation),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int beats_out = 0;
    int frames_done_seen = 0;
    int cyc = 0;

    // Reference model: the words accepted in the current frame, plus the
    // queue of expected output beats that have not been consumed yet.
    logic [DW-1:0] part_q [$];
    logic [DW-1:0] exp_data [$];
    logic [2:0]    exp_rot [$];
    logic          fd_exp = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32 + 1; i++) begin
            w = {w[DW-33:0], $urandom()};
        end
        return w;
    endfunction

    // Word j of the basic frame: lane i holds Re = 16j+i and Im = 0.
    function automatic logic [DW-1:0] mk_ramp(input int j);
        logic [DW-1:0] w;
        logic [CW-1:0] re;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            re = CW'(16 * j + i);
            w[i*LW +: LW] = {re, {CW{1'b0}}};
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] mk_extreme();
        logic [DW-1:0] w;
        for (int i = 0; i < 4; i++) begin
            w[i*LW +: LW] = {17'h10000, 17'h0FFFF};
        end
        return w;
    endfunction

    // A complete frame becomes four expected beats. Beat k gathers lane k
    // of every word, and rotation is 4+k.
    task automatic push_frame();
        logic [DW-1:0] w [4];
        logic [DW-1:0] beat;
        for (int j = 0; j < 4; j++) w[j] = part_q[j];
        for (int k = 0; k < 4; k++) begin
            beat = '0;
            for (int j = 0; j < 4; j++) beat[j*LW +: LW] = w[j][k*LW +: LW];
            exp_data.push_back(beat);
            exp_rot.push_back(3'(4 + k));
        end
        part_q.delete();
    endtask

    always @(posedge clk) cyc++;

    // Monitor and scoreboard. This block samples on the falling edge.
    // Handshakes seen here take effect on the following rising edge.
    always @(negedge clk) begin
        int held;
        if (rst) begin
            chk("rst_out_valid", DW'(out_valid), DW'(0));
            chk("rst_in_ready", DW'(in_ready), DW'(1));
            chk("rst_rotation", DW'(rotation), DW'(3'b100));
            chk("rst_frame_done", DW'(frame_done), DW'(0));
            part_q.delete();
            exp_data.delete();
            exp_rot.delete();
            fd_exp = 1'b0;
        end else begin
            held = (exp_data.size() + 3) / 4;
            chk("frame_done", DW'(frame_done), DW'(fd_exp));
            if (frame_done === 1'b1) frames_done_seen++;
            chk("out_valid", DW'(out_valid), DW'(exp_data.size() != 0));
            chk("in_ready", DW'(in_ready), DW'(held < 2));
            fd_exp = 1'b0;
            if (out_valid === 1'b1 && exp_data.size() != 0) begin
                chk("data_out", data_out, exp_data[0]);
                chk("rotation", DW'(rotation), DW'(exp_rot[0]));
                if (out_ready === 1'b1) begin
                    fd_exp = (exp_rot[0] == 3'b111);
                    void'(exp_data.pop_front());
                    void'(exp_rot.pop_front());
                    beats_out++;
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                part_q.push_back(data_in);
                if (part_q.size() == 4) push_frame();
            end
        end
    end

    task automatic send(input logic [DW-1:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        data_in  = d;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = rand_word();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            data_in = rand_word();
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (exp_data.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_data.size());
        end
        idle(3);
    endtask

    int b0, f0, c0;
    bit snd_done;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single frame with the ramp pattern
        out_ready = 1'b1;
        b0 = beats_out;
        f0 = frames_done_seen;
        for (int j = 0; j < 4; j++) send(mk_ramp(j));
        drain();
        chk("single_beats", DW'(beats_out - b0), DW'(4));
        chk("single_frame_done", DW'(frames_done_seen - f0), DW'(1));

        // Three frames back to back
        b0 = beats_out;
        c0 = cyc;
        for (int n = 0; n < 12; n++) send(rand_word());
        drain();
        chk("b2b_beats", DW'(beats_out - b0), DW'(12));
        chk("b2b_fast", DW'((cyc - c0) <= 12 + 8), DW'(1));

        // Backpressure: two frames fill, then input must stall
        out_ready = 1'b0;
        for (int n = 0; n < 8; n++) send(rand_word());
        in_valid = 1'b1;
        data_in = rand_word();
        repeat (10) @(negedge clk);
        chk("bp_in_ready", DW'(in_ready), DW'(0));
        chk("bp_out_valid", DW'(out_valid), DW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        b0 = beats_out;
        out_ready = 1'b1;
        drain();
        chk("bp_beats", DW'(beats_out - b0), DW'(8));

        // Input stalls with garbage on data_in between beats
        for (int j = 0; j < 4; j++) begin
            send(mk_ramp(j));
            idle(1);
        end
        drain();

        // Reset partway through a frame
        send(rand_word());
        send(rand_word());
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        b0 = beats_out;
        for (int n = 0; n < 4; n++) send(rand_word());
        drain();
        chk("rst_frame_beats", DW'(beats_out - b0), DW'(4));

        // Extreme component values
        for (int n = 0; n < 4; n++) send(mk_extreme());
        drain();

        // Random valid/ready traffic
        snd_done = 1'b0;
        b0 = beats_out;
        fork
            begin
                for (int n = 0; n < 48; n++) begin
                    send(rand_word());
                    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                end
                snd_done = 1'b1;
            end
            begin
                for (int t = 0; t < 5000 && !snd_done; t++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("rand_beats", DW'(beats_out - b0), DW'(48));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
